// File: rtl/pipearch_dma_write_burst.sv
// PipeArch CCI-P c1 DMA write engine with 1/2/4-line burst packing.
// Optional trailing write fence: define PIPEARCH_DMA_WR_FENCE_EN.
module pipearch_dma_write_burst #(
  parameter int DATA_W          = 512,
  parameter int ADDR_W          = 42,
  parameter int LEN_W           = 32,
  parameter int MAX_BURST       = 4,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  start_len,
  output logic              idle,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx_valid,
  output logic [ADDR_W-1:0] tx_addr,
  output logic [DATA_W-1:0] tx_data,
  output logic [1:0]        tx_cl_len,
  output logic              tx_sop,
  output logic              tx_fence,
  input  logic              tx_alm_full,
  input  logic              rsp_valid,
  input  logic              rsp_packed,
  input  logic [1:0]        rsp_cl_num,
  input  logic              rsp_fence,
  output logic              ack_valid,
  output logic [2:0]        ack_lines
);

`ifdef PIPEARCH_DMA_WR_FENCE_EN
  localparam bit FENCE_EN = 1'b1;
`else
  localparam bit FENCE_EN = 1'b0;
`endif

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    S_IDLE, S_SEND, S_FENCE, S_WAIT
  } send_e;

  typedef enum logic [1:0] {
    A_IDLE, A_ACK, A_FENCE, A_DONE
  } ack_e;

  send_e             send_q, send_d;
  ack_e              ack_q, ack_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  sent_q, sent_d;
  logic [LEN_W-1:0]  acked_q, acked_d;
  logic [1:0]        beat_q, beat_d;
  logic [2:0]        bn_q, bn_d;
  logic [OW-1:0]     out_q, out_d;
  logic              tx_valid_q, tx_valid_d;
  logic [ADDR_W-1:0] tx_addr_q, tx_addr_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [1:0]        tx_cl_len_q, tx_cl_len_d;
  logic              tx_sop_q, tx_sop_d;
  logic              tx_fence_q, tx_fence_d;
  logic              done_q, done_d;
  logic              ack_valid_q, ack_valid_d;
  logic [2:0]        ack_lines_q, ack_lines_d;

  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  rem;
  logic [2:0]        n_sel;
  logic [2:0]        cur_n;
  logic              mid;
  logic              credit;
  logic              accept;
  logic              last_beat;
  logic              burst_end;
  logic              go;
  logic              fence_rsp;
  logic              rsp_hit;
  logic [2:0]        k;
  logic [LEN_W:0]    ack_sum;
  logic              all_acked;
  logic [2:0]        inc;
  logic [2:0]        dec;

  function automatic logic [1:0] cl_enc(input logic [2:0] n);
    case (n)
      3'd4:    cl_enc = 2'd3;
      3'd2:    cl_enc = 2'd1;
      default: cl_enc = 2'd0;
    endcase
  endfunction

  // Largest aligned burst that fits the remaining length.
  always_comb begin
    cur_addr = addr_q + ADDR_W'(sent_q);
    rem      = len_q - sent_q;
    n_sel    = 3'd1;
    if (MAX_BURST >= 2 && !cur_addr[0] &&
        rem >= LEN_W'(2))
      n_sel = 3'd2;
    if (MAX_BURST >= 4 && cur_addr[1:0] == 2'b00 &&
        rem >= LEN_W'(4))
      n_sel = 3'd4;
  end

  assign mid    = (beat_q != 2'd0);
  assign credit = ({1'b0, out_q} + (OW+1)'(n_sel))
                  <= (OW+1)'(MAX_OUTSTANDING);
  assign in_ready = (send_q == S_SEND) && !tx_alm_full &&
                    (mid || credit);
  assign accept    = in_valid && in_ready;
  assign cur_n     = mid ? bn_q : n_sel;
  assign last_beat = (sent_q + LEN_W'(1)) == len_q;
  assign burst_end = ({1'b0, beat_q} + 3'd1) == cur_n;
  assign go        = start && idle;

  assign fence_rsp = FENCE_EN && rsp_fence;
  assign rsp_hit   = (ack_q == A_ACK) && rsp_valid && !fence_rsp;
  assign k         = rsp_packed ? ({1'b0, rsp_cl_num} + 3'd1)
                                : 3'd1;
  assign ack_sum   = {1'b0, acked_q} + (LEN_W+1)'(k);
  assign all_acked = ack_sum == {1'b0, len_q};
  assign inc       = (accept && !mid) ? n_sel : 3'd0;
  assign dec       = rsp_hit ? k : 3'd0;

  // Next-state for both FSMs, credit counter and registered outputs.
  always_comb begin
    send_d      = send_q;
    ack_d       = ack_q;
    addr_d      = addr_q;
    len_d       = len_q;
    sent_d      = sent_q;
    acked_d     = acked_q;
    beat_d      = beat_q;
    bn_d        = bn_q;
    out_d       = out_q + OW'(inc) - OW'(dec);
    tx_valid_d  = 1'b0;
    tx_addr_d   = tx_addr_q;
    tx_data_d   = tx_data_q;
    tx_cl_len_d = tx_cl_len_q;
    tx_sop_d    = 1'b0;
    tx_fence_d  = 1'b0;
    done_d      = 1'b0;
    ack_valid_d = rsp_hit;
    ack_lines_d = rsp_hit ? k : 3'd0;

    if (go) begin
      if (start_len != '0) begin
        send_d  = S_SEND;
        ack_d   = A_ACK;
        addr_d  = start_addr;
        len_d   = start_len;
        sent_d  = '0;
        acked_d = '0;
        beat_d  = 2'd0;
        out_d   = '0;
      end else begin
        done_d = 1'b1;
      end
    end

    if (accept) begin
      tx_valid_d  = 1'b1;
      tx_addr_d   = cur_addr;
      tx_data_d   = in_data;
      tx_cl_len_d = cl_enc(cur_n);
      tx_sop_d    = !mid;
      sent_d      = sent_q + LEN_W'(1);
      beat_d      = burst_end ? 2'd0 : beat_q + 2'd1;
      if (!mid)
        bn_d = n_sel;
    end

    case (send_q)
      S_SEND: begin
        if (accept && last_beat)
          send_d = FENCE_EN ? S_FENCE : S_WAIT;
      end
      S_FENCE: begin
        if (!tx_alm_full) begin
          tx_valid_d  = 1'b1;
          tx_fence_d  = 1'b1;
          tx_sop_d    = 1'b1;
          tx_cl_len_d = 2'd0;
          tx_addr_d   = '0;
          send_d      = S_WAIT;
        end
      end
      default: ;
    endcase

    case (ack_q)
      A_ACK: begin
        if (rsp_hit) begin
          acked_d = ack_sum[LEN_W-1:0];
          if (all_acked) begin
            ack_d  = FENCE_EN ? A_FENCE : A_DONE;
            done_d = !FENCE_EN;
          end
        end
      end
      A_FENCE: begin
        if (rsp_valid && fence_rsp) begin
          ack_d  = A_DONE;
          done_d = 1'b1;
        end
      end
      A_DONE: begin
        ack_d  = A_IDLE;
        send_d = S_IDLE;
      end
      default: ;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      send_q      <= S_IDLE;
      ack_q       <= A_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      sent_q      <= '0;
      acked_q     <= '0;
      beat_q      <= 2'd0;
      bn_q        <= 3'd1;
      out_q       <= '0;
      tx_valid_q  <= 1'b0;
      tx_addr_q   <= '0;
      tx_data_q   <= '0;
      tx_cl_len_q <= 2'd0;
      tx_sop_q    <= 1'b0;
      tx_fence_q  <= 1'b0;
      done_q      <= 1'b0;
      ack_valid_q <= 1'b0;
      ack_lines_q <= 3'd0;
    end else begin
      send_q      <= send_d;
      ack_q       <= ack_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      sent_q      <= sent_d;
      acked_q     <= acked_d;
      beat_q      <= beat_d;
      bn_q        <= bn_d;
      out_q       <= out_d;
      tx_valid_q  <= tx_valid_d;
      tx_addr_q   <= tx_addr_d;
      tx_data_q   <= tx_data_d;
      tx_cl_len_q <= tx_cl_len_d;
      tx_sop_q    <= tx_sop_d;
      tx_fence_q  <= tx_fence_d;
      done_q      <= done_d;
      ack_valid_q <= ack_valid_d;
      ack_lines_q <= ack_lines_d;
    end
  end

  assign idle      = (send_q == S_IDLE) && (ack_q == A_IDLE);
  assign busy      = (send_q != S_IDLE);
  assign done      = done_q;
  assign tx_valid  = tx_valid_q;
  assign tx_addr   = tx_addr_q;
  assign tx_data   = tx_data_q;
  assign tx_cl_len = tx_cl_len_q;
  assign tx_sop    = tx_sop_q;
  assign tx_fence  = tx_fence_q;
  assign ack_valid = ack_valid_q;
  assign ack_lines = ack_lines_q;

endmodule

// File: tb/tb_pipearch_dma_write_burst.sv
// Directed bench for pipearch_dma_write_burst.
// Runs with MAX_OUTSTANDING=8 to exercise credit stalls.
module tb_pipearch_dma_write_burst;
  localparam int DW = 512;
  localparam int AW = 42;
  localparam int LW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [LW-1:0] start_len;
  logic          idle, busy, done;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          tx_valid;
  logic [AW-1:0] tx_addr;
  logic [DW-1:0] tx_data;
  logic [1:0]    tx_cl_len;
  logic          tx_sop, tx_fence;
  logic          tx_alm_full;
  logic          rsp_valid, rsp_packed, rsp_fence;
  logic [1:0]    rsp_cl_num;
  logic          ack_valid;
  logic [2:0]    ack_lines;

  always #5 clk = ~clk;

  pipearch_dma_write_burst #(
    .MAX_OUTSTANDING(8)
  ) u_dut (
    .clk(clk), .reset(reset), .start(start),
    .start_addr(start_addr), .start_len(start_len),
    .idle(idle), .busy(busy), .done(done),
    .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .tx_valid(tx_valid),
    .tx_addr(tx_addr), .tx_data(tx_data),
    .tx_cl_len(tx_cl_len), .tx_sop(tx_sop),
    .tx_fence(tx_fence), .tx_alm_full(tx_alm_full),
    .rsp_valid(rsp_valid), .rsp_packed(rsp_packed),
    .rsp_cl_num(rsp_cl_num), .rsp_fence(rsp_fence),
    .ack_valid(ack_valid), .ack_lines(ack_lines)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic          sop;
    logic [1:0]    len;
    logic          fence;
    logic [31:0]   tag;
  } beat_t;

  beat_t       q[$];
  beat_t       mon_b;
  logic [31:0] data_cnt = 32'd0;
  int          done_cnt = 0;
  logic        fence_seen = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] base;

  assign in_data = {{(DW-32){1'b0}}, data_cnt};

  always @(posedge clk)
    if (in_valid && in_ready) data_cnt <= data_cnt + 32'd1;

  always @(negedge clk) begin
    if (tx_valid) begin
      mon_b.addr  = tx_addr;
      mon_b.sop   = tx_sop;
      mon_b.len   = tx_cl_len;
      mon_b.fence = tx_fence;
      mon_b.tag   = tx_data[31:0];
      q.push_back(mon_b);
    end
    if (done) done_cnt = done_cnt + 1;
    if (tx_fence) fence_seen = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [AW-1:0] a,
                          input logic [LW-1:0] n);
    start      = 1'b1;
    start_addr = a;
    start_len  = n;
    tick();
    start = 1'b0;
  endtask

  task automatic rsp(input logic pk,
                     input logic [1:0] num,
                     input logic fn);
    rsp_valid  = 1'b1;
    rsp_packed = pk;
    rsp_cl_num = num;
    rsp_fence  = fn;
    tick();
    rsp_valid  = 1'b0;
    rsp_packed = 1'b0;
    rsp_cl_num = 2'd0;
    rsp_fence  = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget);
    int c;
    c = 0;
    while (q.size() < n && c < budget) begin
      tick();
      c++;
    end
    chk("beat_count", 64'(q.size()), 64'(n));
  endtask

  task automatic chk_beat(input int i,
                          input logic [AW-1:0] a,
                          input logic s,
                          input logic [1:0] l,
                          input logic [31:0] t);
    beat_t b;
    b = q[i];
    chk($sformatf("addr[%0d]", i), 64'(b.addr), 64'(a));
    chk($sformatf("sop[%0d]", i), 64'(b.sop), 64'(s));
    chk($sformatf("cl_len[%0d]", i), 64'(b.len), 64'(l));
    chk($sformatf("tag[%0d]", i), 64'(b.tag), 64'(t));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a2[6];
    logic          s2[6];
    logic [1:0]    l2[6];
    reset = 1'b1; start = 1'b0;
    start_addr = '0; start_len = '0;
    in_valid = 1'b1; tx_alm_full = 1'b0;
    rsp_valid = 1'b0; rsp_packed = 1'b0;
    rsp_cl_num = 2'd0; rsp_fence = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_tx_valid", 64'(tx_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ack_valid", 64'(ack_valid), 64'd0);
    chk("rst_ack_lines", 64'(ack_lines), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);

    // Aligned 8 lines -> two 4-line bursts.
    q.delete();
    base = data_cnt;
    do_start(42'h100, 32'd8);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_in_ready", 64'(in_ready), 64'd1);
    wait_beats(8, 40);
    for (int i = 0; i < 8; i++)
      chk_beat(i, 42'h100 + AW'(i), (i % 4) == 0,
               2'd3, base + 32'(i));
    chk("t1_wait_ready", 64'(in_ready), 64'd0);
    rsp(1'b0, 2'd0, 1'b0);
    chk("t1_ack_valid", 64'(ack_valid), 64'd1);
    chk("t1_ack_lines", 64'(ack_lines), 64'd1);
    repeat (6) rsp(1'b0, 2'd0, 1'b0);
    chk("t1_done_early", 64'(done), 64'd0);
    rsp(1'b0, 2'd0, 1'b0);
    chk("t1_done", 64'(done), 64'd1);
    tick();
    chk("t1_done_pulse", 64'(done), 64'd0);
    chk("t1_idle", 64'(idle), 64'd1);

    // Misaligned start -> 1,2,2,1 bursts.
    q.delete();
    base = data_cnt;
    a2 = '{42'h101, 42'h102, 42'h103,
           42'h104, 42'h105, 42'h106};
    s2 = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    l2 = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
    do_start(42'h101, 32'd6);
    wait_beats(6, 30);
    for (int i = 0; i < 6; i++)
      chk_beat(i, a2[i], s2[i], l2[i], base + 32'(i));
    rsp(1'b1, 2'd3, 1'b0);
    chk("t2_ack4", 64'(ack_lines), 64'd4);
    rsp(1'b1, 2'd1, 1'b0);
    chk("t2_ack2", 64'(ack_lines), 64'd2);
    chk("t2_done", 64'(done), 64'd1);
    tick();
    chk("t2_idle", 64'(idle), 64'd1);

    // Credit limit of 8 lines.
    q.delete();
    base = data_cnt;
    do_start(42'h200, 32'd16);
    repeat (20) tick();
    chk("t3_stall_cnt", 64'(q.size()), 64'd8);
    chk("t3_stall_ready", 64'(in_ready), 64'd0);
    rsp(1'b1, 2'd3, 1'b0);
    chk("t3_ack_lines", 64'(ack_lines), 64'd4);
    chk("t3_resume_ready", 64'(in_ready), 64'd1);
    wait_beats(12, 20);
    chk_beat(8, 42'h208, 1'b1, 2'd3, base + 32'd8);
    chk("t3_stall2_ready", 64'(in_ready), 64'd0);
    rsp(1'b1, 2'd3, 1'b0);
    wait_beats(16, 20);
    for (int i = 0; i < 16; i++)
      chk($sformatf("t3_addr[%0d]", i),
          64'(q[i].addr), 64'(42'h200 + AW'(i)));
    rsp(1'b1, 2'd3, 1'b0);
    chk("t3_done_early", 64'(done), 64'd0);
    rsp(1'b1, 2'd3, 1'b0);
    chk("t3_done", 64'(done), 64'd1);
    tick();
    chk("t3_idle", 64'(idle), 64'd1);

    // Almost-full stall in the middle of a burst.
    q.delete();
    base = data_cnt;
    do_start(42'h300, 32'd4);
    tick();
    tick();
    tx_alm_full = 1'b1;
    #1;
    chk("t4_af_ready", 64'(in_ready), 64'd0);
    repeat (5) tick();
    chk("t4_af_cnt", 64'(q.size()), 64'd2);
    chk("t4_af_txv", 64'(tx_valid), 64'd0);
    tx_alm_full = 1'b0;
    wait_beats(4, 10);
    for (int i = 0; i < 4; i++)
      chk_beat(i, 42'h300 + AW'(i), i == 0,
               2'd3, base + 32'(i));
    rsp(1'b1, 2'd3, 1'b0);
    chk("t4_done", 64'(done), 64'd1);
    tick();

    // Zero-length command.
    q.delete();
    do_start(42'h0, 32'd0);
    chk("t5_done", 64'(done), 64'd1);
    chk("t5_idle", 64'(idle), 64'd1);
    tick();
    chk("t5_done_pulse", 64'(done), 64'd0);
    chk("t5_no_tx", 64'(q.size()), 64'd0);

    // Reset mid-transfer, then a fresh 2-line transfer.
    do_start(42'h400, 32'd8);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_idle", 64'(idle), 64'd1);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_txv", 64'(tx_valid), 64'd0);
    rsp(1'b0, 2'd0, 1'b0);
    chk("t6_stale_ack", 64'(ack_valid), 64'd0);
    q.delete();
    base = data_cnt;
    do_start(42'h500, 32'd2);
`ifdef PIPEARCH_DMA_WR_FENCE_EN
    wait_beats(3, 10);
    chk_beat(0, 42'h500, 1'b1, 2'd1, base);
    chk_beat(1, 42'h501, 1'b0, 2'd1, base + 32'd1);
    chk("t7_fence", 64'(q[2].fence), 64'd1);
    chk("t7_fence_sop", 64'(q[2].sop), 64'd1);
    chk("t7_fence_len", 64'(q[2].len), 64'd0);
    chk("t7_fence_addr", 64'(q[2].addr), 64'd0);
    rsp(1'b1, 2'd1, 1'b0);
    chk("t7_done_held", 64'(done), 64'd0);
    repeat (2) tick();
    chk("t7_done_held2", 64'(done), 64'd0);
    chk("t7_not_idle", 64'(idle), 64'd0);
    rsp(1'b0, 2'd0, 1'b1);
    chk("t7_done", 64'(done), 64'd1);
    tick();
    chk("t7_done_pulse", 64'(done), 64'd0);
    chk("t7_idle", 64'(idle), 64'd1);
    chk("done_count", 64'(done_cnt), 64'd6);
`else
    wait_beats(2, 10);
    chk_beat(0, 42'h500, 1'b1, 2'd1, base);
    chk_beat(1, 42'h501, 1'b0, 2'd1, base + 32'd1);
    rsp(1'b1, 2'd1, 1'b0);
    chk("t6_done", 64'(done), 64'd1);
    tick();
    chk("t6_idle", 64'(idle), 64'd1);
    repeat (3) tick();
    chk("no_extra_tx", 64'(q.size()), 64'd2);
    chk("no_fence", 64'(fence_seen), 64'd0);
    chk("done_count", 64'(done_cnt), 64'd6);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pipearch_dma_write_burst.md
Name: pipearch_dma_write_burst

Overview:
- Next-generation DMA write engine for the PipeArch CCI-P channel 1 (c1) write path.
- Streams a contiguous region of LEN cache lines from a valid/ready data source to host memory starting at ADDR.
- Packs lines into 1/2/4-line multi-line bursts where alignment allows, bounds outstanding lines with a credit counter, and accounts for packed write responses.
- Sits between the accelerator write pipeline and the CCI-P c1 Tx/Rx ports; one engine per write stream.

Parameters:
- DATA_W, 512, cache-line width in bits.
- ADDR_W, 42, cache-line address width.
- LEN_W, 32, transfer-length width in lines.
- MAX_BURST, 4, largest burst in lines; legal values 1, 2, 4.
- MAX_OUTSTANDING, 64, maximum lines sent but not yet acknowledged; must be >= MAX_BURST.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle command strobe.
- start_addr  in  ADDR_W  first line address.
- start_len  in  LEN_W  number of lines.
- idle  out  1  both the send FSM and the ack FSM are IDLE.
- busy  out  1  send FSM not IDLE.
- done  out  1  one-cycle completion pulse.
- in_valid  in  1  write data valid.
- in_data  in  DATA_W  write data.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- tx_valid  out  1  c1 request valid.
- tx_addr  out  ADDR_W  request line address.
- tx_data  out  DATA_W  request data.
- tx_cl_len  out  2  burst length: 0=1 line, 1=2 lines, 3=4 lines.
- tx_sop  out  1  first beat of burst.
- tx_fence  out  1  request is a write fence.
- tx_alm_full  in  1  c1 Tx almost full.
- rsp_valid  in  1  c1 write response.
- rsp_packed  in  1  response acknowledges rsp_cl_num+1 lines.
- rsp_cl_num  in  2  packed line count minus 1.
- rsp_fence  in  1  response is a fence acknowledgement.
- ack_valid  out  1  lines acknowledged this cycle.
- ack_lines  out  3  number of lines acknowledged (1..4).

Behaviour:
- Reset: both FSMs to IDLE; all counters cleared; tx_valid, tx_sop, tx_fence, done, ack_valid = 0; ack_lines = 0. A reset mid-transfer abandons the transfer. Responses arriving after reset are ignored because the ack FSM is IDLE.
- Send FSM states and transitions:
  - IDLE -> SEND on start with start_len != 0. Latch addr/len; clear sent, outstanding and beat counters.
  - start with start_len == 0: no data transfer; done pulses the cycle after start.
  - start while not idle is ignored.
- Burst selection (at each burst boundary):
  - N = largest of {4, 2, 1} with N <= MAX_BURST, (addr+sent) mod N == 0, and len-sent >= N.
  - Burst start is allowed only if outstanding + N <= MAX_OUTSTANDING.
- in_ready = SEND && !tx_alm_full && (mid-burst || credit available). Combinational from registered state and tx_alm_full.
- Beat accepted in cycle t: tx_valid=1 in t+1 with tx_data=in_data.
  - tx_addr = base + beat index.
  - tx_sop = 1 on beat 0 only.
  - tx_cl_len encodes N on every beat of the burst.
  - All tx_* fields are registered; tx_valid otherwise 0.
- Outstanding increments by N at burst start and decrements by the acknowledged count. Simultaneous increment and decrement net correctly within one cycle. Widths are sized for MAX_OUTSTANDING.
- Ack FSM states and transitions:
  - IDLE -> ACK on start with start_len != 0.
  - In ACK, each non-fence rsp_valid adds k = rsp_packed ? rsp_cl_num+1 : 1 to acked. The same cycle's ack_valid=1 and ack_lines=k appear registered at t+1.
  - When acked + k == len: ACK -> DONE, done=1 in t+1, then both FSMs return to IDLE.
- Send FSM SEND -> WAIT after the last beat is accepted; WAIT returns to IDLE together with the ack FSM.
- Arithmetic: address sums are modulo 2^ADDR_W (wrap permitted). The length compare uses the full LEN_W width.

Optional Feature:
- Macro: PIPEARCH_DMA_WR_FENCE_EN.
- Enabled: after the last data beat, and once tx_alm_full=0, one request is issued with tx_valid=1, tx_fence=1, tx_sop=1, tx_cl_len=0, tx_addr=0. After all lines are acknowledged, done is withheld until an rsp_valid with rsp_fence=1 arrives; done pulses the cycle after it.
- Disabled: tx_fence held 0, rsp_fence ignored, no fence request issued.

Test Plan:
- start_addr=0x100, start_len=8, in_valid always 1, single responses -> two 4-line bursts with tx_addr 0x100..0x107, sop on 0x100 and 0x104, tx_cl_len=3. done one cycle after 8th response.
- start_addr=0x101, start_len=6 -> bursts of 1 (0x101), 2 (0x102-0x103), 2 (0x104-0x105), 1 (0x106).
- MAX_OUTSTANDING=8, start_len=16, no responses -> exactly 8 lines sent and in_ready=0. One packed response (rsp_cl_num=3) -> next 4-line burst proceeds. ack_lines=4.
- tx_alm_full=1 mid-burst for 5 cycles -> in_ready=0, no tx_valid; burst resumes with correct addresses afterwards.
- start_len=0 -> no tx_valid, done=1 the cycle after start. Reset asserted after 3 of 8 lines -> idle=1 next cycle; a subsequent start_len=2 completes normally.
- With PIPEARCH_DMA_WR_FENCE_EN, start_len=2 -> fence request follows the last data beat. done stays low until rsp_fence, then pulses once.
